// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the VGA pixel port between two burst requesters and a full-screen clear sweep
module plot_arbiter #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119,
  parameter logic [CW-1:0] CLEAR_COLOR = '0,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          clear_busy,
  input  logic          req_a,
  input  logic [XW-1:0] x_a,
  input  logic [YW-1:0] y_a,
  input  logic [CW-1:0] c_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [XW-1:0] x_b,
  input  logic [YW-1:0] y_b,
  input  logic [CW-1:0] c_b,
  output logic          gnt_b,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic [CW-1:0] color,
  output logic          plot
);
  localparam int NW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, CLEAR} state_t;
  state_t state;
  logic clear_pending, rr_b;
  logic [NW-1:0] cnt;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic acc, pick_a, last_burst, x_end, last_px;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
  logic [CW-1:0] c_o;
  // accept qualification, owner pixel mux and round-robin choice
  always_comb begin
    acc = (state == OWN_A && req_a) || (state == OWN_B && req_b);
    x_o = state == OWN_A ? x_a : x_b;
    y_o = state == OWN_A ? y_a : y_b;
    c_o = state == OWN_A ? c_a : c_b;
    pick_a = req_a && (!req_b || rr_b);
    last_burst = cnt == NW'(MAX_BURST - 1);
    x_end = cx == XW'(XMAX);
    last_px = x_end && cy == YW'(YMAX);
  end
  // arbitration FSM with registered pixel port, grants and clear bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      xpos <= '0;
      ypos <= '0;
      color <= '0;
      plot <= 1'b0;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      clear_busy <= 1'b0;
      clear_pending <= 1'b0;
      cnt <= '0;
      rr_b <= 1'b1;
      cx <= '0;
      cy <= '0;
    end else begin
      plot <= 1'b0;
      if (clear_req && !clear_pending && state != CLEAR) begin
        clear_pending <= 1'b1;
        clear_busy <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clear_pending) begin
            state <= CLEAR;
          end else if (req_a || req_b) begin
            state <= pick_a ? OWN_A : OWN_B;
            gnt_a <= pick_a;
            gnt_b <= !pick_a;
            rr_b <= !pick_a;
          end
        end
        OWN_A, OWN_B: begin
          if (acc) begin
            xpos <= x_o;
            ypos <= y_o;
            color <= c_o;
            plot <= 1'b1;
            cnt <= cnt + 1'b1;
          end
          if (!acc || last_burst) begin
            state <= IDLE;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            cnt <= '0;
          end
        end
        default: begin
          xpos <= cx;
          ypos <= cy;
          color <= CLEAR_COLOR;
          plot <= 1'b1;
          cx <= x_end ? '0 : cx + 1'b1;
          cy <= x_end ? cy + 1'b1 : cy;
          if (last_px) begin
            state <= IDLE;
            clear_pending <= 1'b0;
            clear_busy <= 1'b0;
            cx <= '0;
            cy <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: randomized and directed scoreboard bench for plot_arbiter
module tb_plot_arbiter;
  localparam int MAXB = 16;
  localparam int W = 160;
  localparam int H = 120;
  logic clk = 1'b0, reset = 1'b0, clear_req = 1'b0, clear_busy;
  logic req_a = 1'b0, req_b = 1'b0, gnt_a, gnt_b, plot;
  logic [7:0] x_a = '0, x_b = '0, xpos;
  logic [6:0] y_a = '0, y_b = '0, ypos;
  logic [2:0] c_a = '0, c_b = '0, color;
  int checks = 0, failures = 0, plots = 0;
  int m_own, m_cnt, m_rr, m_k;
  bit m_pend, m_busy;
  logic [17:0] q[$];

  plot_arbiter dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .req_a(req_a), .x_a(x_a), .y_a(y_a), .c_a(c_a), .gnt_a(gnt_a),
    .req_b(req_b), .x_b(x_b), .y_b(y_b), .c_b(c_b), .gnt_b(gnt_b),
    .xpos(xpos), .ypos(ypos), .color(color), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // reference model: owner 0=none 1=A 2=B 3=clear; rr holds last granted requester
  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_rr = 2; m_k = 0; m_pend = 0; m_busy = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit op = m_pend;
    int g;
    if (clear_req && !m_pend && m_own != 3) begin
      m_pend = 1; m_busy = 1;
    end
    case (m_own)
      0: begin
        if (op) begin
          m_own = 3; m_k = 0;
        end else if (req_a || req_b) begin
          g = (req_a && req_b) ? (m_rr == 2 ? 1 : 2) : (req_a ? 1 : 2);
          m_rr = g; m_own = g;
        end
      end
      1, 2: begin
        if (m_own == 1 ? req_a : req_b) begin
          q.push_back(m_own == 1 ? {x_a, y_a, c_a} : {x_b, y_b, c_b});
          m_cnt++;
          if (m_cnt == MAXB) begin m_own = 0; m_cnt = 0; end
        end else begin
          m_own = 0; m_cnt = 0;
        end
      end
      default: begin
        q.push_back({8'(m_k % W), 7'(m_k / W), 3'd0});
        m_k++;
        if (m_k == W * H) begin m_own = 0; m_pend = 0; m_busy = 0; end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_a = 0; req_b = 0; clear_req = 0;
    model_reset();
    #1;
    chk("rst_outputs", {plot, gnt_a, gnt_b, clear_busy, xpos, ypos, color}, '0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_clear(input bit second_req);
    for (int i = 0; i < W * H + 10 && m_busy; i++) begin
      clear_req = second_req && i == 300;
      tick();
    end
    clear_req = 1'b0;
    chk("clear_done_busy", clear_busy, 0);
  endtask

  // monitor: compares grants/busy against the model and pops expected pixels on plot
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      chk("gnt_a", gnt_a, m_own == 1);
      chk("gnt_b", gnt_b, m_own == 2);
      chk("gnt_excl", gnt_a & gnt_b, 0);
      chk("clear_busy", clear_busy, m_busy);
      if (plot) begin
        plots++;
        if (q.size() == 0) chk("plot_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("pixel", {xpos, ypos, color}, e);
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        chk("plot_missing", {1'b0, xpos, ypos, color}, {1'b1, e});
      end
    end
  end

  initial begin
    int p0;
    model_reset();
    @(negedge clk);
    do_reset();
    // single requester burst of five pixels
    x_a = 10; y_a = 20; c_a = 5; req_a = 1;
    tick();
    chk("s1_grant", gnt_a, 1);
    p0 = plots;
    repeat (5) tick();
    req_a = 0;
    tick();
    chk("s1_gnt_drop", gnt_a, 0);
    tick();
    chk("s1_plots", plots - p0, 5);
    // round robin from reset
    do_reset();
    req_a = 1; req_b = 1; x_a = 1; x_b = 2;
    tick();
    chk("rr_first_a", gnt_a, 1);
    repeat (3) tick();
    req_a = 0;
    tick();
    tick();
    chk("rr_then_b", gnt_b, 1);
    repeat (2) tick();
    req_a = 1; req_b = 0;
    tick();
    req_b = 1;
    tick();
    chk("rr_back_a", gnt_a, 1);
    req_a = 0; req_b = 0;
    repeat (2) tick();
    // burst cap with B waiting
    do_reset();
    req_a = 1; req_b = 1; x_a = 33; c_a = 3;
    tick();
    p0 = plots;
    repeat (MAXB) tick();
    chk("cap_gnt_a_drop", gnt_a, 0);
    tick();
    chk("cap_b_next", gnt_b, 1);
    chk("cap_plots", plots - p0, MAXB);
    // burst cap with A alone: regrant after one idle cycle
    do_reset();
    req_a = 1;
    tick();
    repeat (MAXB) tick();
    chk("cap_idle", gnt_a, 0);
    tick();
    chk("cap_regrant", gnt_a, 1);
    // full clear with a redundant second request mid-sweep
    do_reset();
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("clr_busy_rise", clear_busy, 1);
    p0 = plots;
    run_clear(1);
    tick();
    chk("clr_plots", plots - p0, W * H);
    chk("clr_last_px", {xpos, ypos}, {8'd159, 7'd119});
    repeat (3) tick();
    chk("clr_no_rerun", plot, 0);
    // clear arriving while B owns the port
    do_reset();
    req_b = 1; x_b = 77; y_b = 9; c_b = 6;
    repeat (4) tick();
    clear_req = 1;
    tick();
    clear_req = 0; req_a = 1;
    repeat (4) tick();
    req_b = 0;
    tick();
    tick();
    chk("own_clr_no_grant", gnt_a, 0);
    run_clear(0);
    tick();
    chk("own_clr_then_a", gnt_a, 1);
    // reset mid-clear
    do_reset();
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int i = 0; i < 600 && m_k < 500; i++) tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_clear", {plot, clear_busy, gnt_a, gnt_b}, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (20) tick();
    chk("no_resume", {plot, clear_busy}, 0);
    // randomized traffic with one clear request
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_a = ($urandom % 4) != 0;
      req_b = ($urandom % 3) != 0;
      x_a = 8'($urandom); y_a = 7'($urandom); c_a = 3'($urandom);
      x_b = 8'($urandom); y_b = 7'($urandom); c_b = 3'($urandom);
      clear_req = i == 1000;
      tick();
    end
    req_a = 0; req_b = 0; clear_req = 0;
    run_clear(0);
    repeat (5) tick();
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA pixel-write port (xpos/ypos/color/plot) between two drawing requesters, A and B, plus a built-in full-screen clear engine.
- Requesters own the port in bursts under a req/gnt handshake, with round-robin fairness and a burst-length cap.
- A clear request sweeps the whole 160x120 frame with a fixed colour.
- Sits between the drawing engines and the VGA adapter in the processor top level.

Parameters:
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- XMAX, 159, last column
- YMAX, 119, last row
- CLEAR_COLOR, 3'b000, colour written by the clear sweep
- MAX_BURST, 16, maximum pixels accepted per ownership (must be >= 1)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- clear_req  in  1  single-cycle pulse requesting a screen clear
- clear_busy  out  1  high from clear acceptance until the sweep finishes
- req_a  in  1  requester A wants the port / has a valid pixel
- x_a  in  XW  requester A pixel x
- y_a  in  YW  requester A pixel y
- c_a  in  CW  requester A pixel colour
- gnt_a  out  1  A owns the port
- req_b, x_b, y_b, c_b, gnt_b  as for A
- xpos  out  XW  pixel x to VGA adapter
- ypos  out  YW  pixel y to VGA adapter
- color  out  CW  pixel colour to VGA adapter
- plot  out  1  pixel write strobe

Behaviour:
- Reset (reset low, asynchronous): state IDLE; xpos, ypos, color = 0; plot = 0; gnt_a = gnt_b = 0; clear_busy = 0; clear_pending = 0; burst count = 0; RR pointer = B, so A wins the first tie.
- All outputs are registered.
- Pixel accept rule: a pixel is accepted on a rising edge where req_x && gnt_x.
  - On the next cycle, xpos/ypos/color hold that pixel and plot = 1. Latency is 1 cycle.
  - Any cycle with no accept and no clear pixel: plot = 0; xpos/ypos/color hold their last values.
- Clear latch: a clear_req seen while clear_pending = 0 and not in CLEAR sets clear_pending and clear_busy on the next cycle. clear_req while clear_pending or in CLEAR is ignored.
- State machine: IDLE, OWN_A, OWN_B, CLEAR.
- IDLE:
  - If clear_pending: go to CLEAR (clear has priority over both requesters).
  - Else if only one requester is asserting req: grant it.
  - Else if both: grant the one not equal to the RR pointer.
  - On a grant, the RR pointer is set to the granted requester.
  - gnt_x rises on the cycle the state becomes OWN_x. No accept occurs in IDLE.
- OWN_x:
  - Each accept increments the burst count.
  - Leave to IDLE (gnt_x low the next cycle) when req_x is low at the edge, or when an accept brings the count to MAX_BURST.
  - On exit, the burst count clears.
  - This gives at least one idle cycle between owners. A requester whose burst was capped keeps req high and waits for a regrant.
- clear_pending does not pre-empt an owner; it is serviced at the next IDLE.
- CLEAR:
  - Internal counters cx, cy start at 0. Each cycle emits one pixel with plot = 1 and color = CLEAR_COLOR, 1-cycle output latency.
  - Sweep order is row-major, cx fastest: cx wraps XMAX->0 and increments cy.
  - After pixel (XMAX, YMAX) is emitted: state returns to IDLE, clear_pending = 0, and clear_busy drops in the same cycle plot of the last pixel is seen.
  - A full sweep is 19200 plot cycles. gnt_a and gnt_b stay 0 throughout.
- Requester inputs (x_*, y_*, c_*) are sampled only on an accept edge. req may drop at any time without penalty.
- Reset asserted mid-burst or mid-clear: the operation is aborted immediately and all state returns to reset values. The clear is not resumed.
- gnt_a and gnt_b are never both high.
- plot is never high for a pixel that was not accepted or generated by the clear sweep.

Test Plan:
- Single requester burst: release reset, then hold req_a = 1 with x_a = 10, y_a = 20, c_a = 5 for 5 cycles after gnt_a, then drop req_a -> exactly 5 plot pulses with (10, 20, 5), each 1 cycle after its accept; gnt_a drops the cycle after req_a falls.
- Round robin with both requesting from reset: A is granted first; after A drops, B is granted; with both requesting again, A is granted. There is one idle cycle between owners and gnt_a & gnt_b is never both high.
- Burst cap with MAX_BURST = 16 and req_a held continuously while req_b = 1: A gets exactly 16 plots, gnt_a drops, B is granted next. With req_b = 0 instead, A is regranted after one IDLE cycle.
- Screen clear: pulse clear_req in IDLE -> clear_busy rises; 19200 consecutive plot cycles with color 0, first pixel (0,0), pixel 160 at (0,1), last pixel (159,119); clear_busy falls with the last pixel. A second clear_req during the sweep produces no extra sweep.
- Clear during ownership: clear_req while B is mid-burst -> B's burst completes, then CLEAR runs before any new grant, even if req_a is high.
- Reset mid-clear: assert reset at pixel 500 of the sweep -> plot, clear_busy, gnt_a and gnt_b are 0 immediately. After release, the state is IDLE and no sweep resumes.
